// File: rtl/instr_encoder_loader_if.sv
// Instruction stream handshake: one mnemonic plus operand fields per accepted beat.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op_sel;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [2:0]  rn;
  logic [10:0] imm;

  modport master (output in_valid, op_sel, rd, rm, rn, imm, input in_ready);
  modport slave  (input in_valid, op_sel, rd, rm, rn, imm, output in_ready);
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic/operand beats into 16-bit instruction words and writes them
// sequentially into instruction memory from BASE_ADDR until HLT or memory full.
module instr_encoder_loader #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  instr_encoder_loader_if.slave in_if,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_illegal_o,
  output logic                  err_overflow_o,
  output logic [ADDR_W:0]       word_count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  typedef enum logic [4:0] {
    OP_MOV, OP_ADDI, OP_SUBI, OP_LHI, OP_LLI, OP_LDR, OP_STR, OP_ADD,
    OP_ADC, OP_SUB, OP_SBB, OP_CMP, OP_BCC, OP_BCS, OP_BNE, OP_BEQ,
    OP_BAL, OP_JMP, OP_JAL_LABEL, OP_JAL_RM, OP_JR, OP_OUTR, OP_HLT
  } op_e;

  typedef struct packed {
    logic        legal;
    logic [15:0] word;
  } enc_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  function automatic enc_t encode(input logic [4:0] op, input logic [2:0] rd,
                                  input logic [2:0] rm, input logic [2:0] rn,
                                  input logic [10:0] imm);
    enc_t e;
    e.legal = 1'b1;
    e.word  = '0;
    case (op_e'(op))
      OP_MOV:       e.word = {5'b01011, rd, rm, 5'b00000};
      OP_ADDI:      e.word = {5'b00111, rd, rm, imm[4:0]};
      OP_SUBI:      e.word = {5'b01000, rd, rm, imm[4:0]};
      OP_LHI:       e.word = {5'b00001, rd, imm[7:0]};
      OP_LLI:       e.word = {5'b00010, rd, imm[7:0]};
      OP_JAL_LABEL: e.word = {5'b10001, rd, imm[7:0]};
      OP_LDR:       e.word = {5'b00011, rd, rm, rn, 2'b00};
      OP_STR:       e.word = {5'b00101, rd, rm, rn, 2'b00};
      OP_ADD:       e.word = {5'b00000, rd, rm, rn, 2'b00};
      OP_ADC:       e.word = {5'b00000, rd, rm, rn, 2'b01};
      OP_SUB:       e.word = {5'b00000, rd, rm, rn, 2'b10};
      OP_SBB:       e.word = {5'b00000, rd, rm, rn, 2'b11};
      OP_CMP:       e.word = {5'b00110, 3'b000, rm, rn, 2'b01};
      OP_BCC:       e.word = {8'hC3, imm[7:0]};
      OP_BCS:       e.word = {8'hC2, imm[7:0]};
      OP_BNE:       e.word = {8'hC1, imm[7:0]};
      OP_BEQ:       e.word = {8'hC0, imm[7:0]};
      OP_BAL:       e.word = {8'hCE, imm[7:0]};
      OP_JMP:       e.word = {5'b10000, imm};
      OP_JAL_RM:    e.word = {5'b10010, rd, rm, 5'b00000};
      OP_JR:        e.word = {5'b10011, 3'b000, rm, 5'b00000};
      OP_OUTR:      e.word = {5'b11100, 3'b000, rm, 5'b00000};
      OP_HLT:       e.word = 16'hE001;
      default:      e.legal = 1'b0;
    endcase
    return e;
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              err_ill_q;
  logic              err_ovf_q;
  enc_t              enc_d;
  logic              accept;

  // start blocks the handshake so a restart never swallows a beat.
  assign in_if.in_ready = (state_q == ST_LOAD) && !start_i;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign enc_d          = encode(in_if.op_sel, in_if.rd, in_if.rm, in_if.rn, in_if.imm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_ill_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      // NOTE: default first; a later non-blocking assignment in this block wins, so the strobe lasts one cycle.
      mem_we_q <= 1'b0;
      if (start_i) begin
        state_q   <= ST_LOAD;
        ptr_q     <= BASE_ADDR;
        count_q   <= '0;
        err_ill_q <= 1'b0;
        err_ovf_q <= 1'b0;
      end else if (accept) begin
        if (!enc_d.legal) begin
          err_ill_q <= 1'b1;
        end else begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= ptr_q;
          mem_wdata_q <= enc_d.word;
          count_q     <= count_q + (ADDR_W + 1)'(1);
          if (op_e'(in_if.op_sel) == OP_HLT) begin
            state_q <= ST_DONE;
          end else if (ptr_q == LAST_ADDR) begin
            err_ovf_q <= 1'b1;
            state_q   <= ST_DONE;
          end
          if (ptr_q != LAST_ADDR) ptr_q <= ptr_q + ADDR_W'(1);
        end
      end
    end
  end

  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign busy_o         = (state_q == ST_LOAD);
  assign done_o         = (state_q == ST_DONE);
  assign err_illegal_o  = err_ill_q;
  assign err_overflow_o = err_ovf_q;
  assign word_count_o   = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Drives one shared instruction stream into an 8-bit and a 2-bit address loader
// and compares both against a transaction-level reference model every cycle.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        valid;
  logic [4:0]  op;
  logic [2:0]  rd, rm, rn;
  logic [10:0] imm;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder_loader_if if8 ();
  instr_encoder_loader_if if2 ();

  assign if8.in_valid = valid;
  assign if8.op_sel   = op;
  assign if8.rd       = rd;
  assign if8.rm       = rm;
  assign if8.rn       = rn;
  assign if8.imm      = imm;
  assign if2.in_valid = valid;
  assign if2.op_sel   = op;
  assign if2.rd       = rd;
  assign if2.rm       = rm;
  assign if2.rn       = rn;
  assign if2.imm      = imm;

  logic        we8, busy8, done8, ill8, ovf8;
  logic [7:0]  addr8;
  logic [15:0] wd8;
  logic [8:0]  cnt8;
  logic        we2, busy2, done2, ill2, ovf2;
  logic [1:0]  addr2;
  logic [15:0] wd2;
  logic [2:0]  cnt2;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut8 (
    .clk(clk), .rst(rst), .start_i(start), .in_if(if8.slave),
    .mem_we_o(we8), .mem_addr_o(addr8), .mem_wdata_o(wd8),
    .busy_o(busy8), .done_o(done8), .err_illegal_o(ill8),
    .err_overflow_o(ovf8), .word_count_o(cnt8)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst(rst), .start_i(start), .in_if(if2.slave),
    .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wd2),
    .busy_o(busy2), .done_o(done2), .err_illegal_o(ill2),
    .err_overflow_o(ovf2), .word_count_o(cnt2)
  );

  logic        o_rdy [2];
  logic        o_we  [2];
  logic        o_busy[2];
  logic        o_done[2];
  logic        o_ill [2];
  logic        o_ovf [2];
  logic [7:0]  o_addr[2];
  logic [15:0] o_wd  [2];
  logic [8:0]  o_cnt [2];

  assign o_rdy[0]  = if8.in_ready;
  assign o_rdy[1]  = if2.in_ready;
  assign o_we[0]   = we8;
  assign o_we[1]   = we2;
  assign o_busy[0] = busy8;
  assign o_busy[1] = busy2;
  assign o_done[0] = done8;
  assign o_done[1] = done2;
  assign o_ill[0]  = ill8;
  assign o_ill[1]  = ill2;
  assign o_ovf[0]  = ovf8;
  assign o_ovf[1]  = ovf2;
  assign o_addr[0] = addr8;
  assign o_addr[1] = {6'd0, addr2};
  assign o_wd[0]   = wd8;
  assign o_wd[1]   = wd2;
  assign o_cnt[0]  = cnt8;
  assign o_cnt[1]  = {6'd0, cnt2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: load phase 0=idle, 1=loading, 2=finished.
  int m_phase[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_addr[2];
  int m_wd[2];
  bit m_ill[2];
  bit m_ovf[2];
  bit m_we[2];

  function automatic int depth(input int d);
    return (d == 0) ? 256 : 4;
  endfunction

  function automatic int encode(input int o, input int a, input int b, input int c, input int i);
    case (o)
      0:  return (11 << 11) + (a << 8) + (b << 5);
      1:  return (7 << 11) + (a << 8) + (b << 5) + (i % 32);
      2:  return (8 << 11) + (a << 8) + (b << 5) + (i % 32);
      3:  return (1 << 11) + (a << 8) + (i % 256);
      4:  return (2 << 11) + (a << 8) + (i % 256);
      5:  return (3 << 11) + (a << 8) + (b << 5) + (c << 2);
      6:  return (5 << 11) + (a << 8) + (b << 5) + (c << 2);
      7, 8, 9, 10: return (a << 8) + (b << 5) + (c << 2) + (o - 7);
      11: return (6 << 11) + (b << 5) + (c << 2) + 1;
      12, 13, 14, 15: return ((32'hC3 - (o - 12)) << 8) + (i % 256);
      16: return (32'hCE << 8) + (i % 256);
      17: return (16 << 11) + i;
      18: return (17 << 11) + (a << 8) + (i % 256);
      19: return (18 << 11) + (a << 8) + (b << 5);
      20: return (19 << 11) + (b << 5);
      21: return (28 << 11) + (b << 5);
      default: return 32'hE001;
    endcase
  endfunction

  task automatic model_edge(input int d);
    if (rst) begin
      m_phase[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_addr[d] = 0;
      m_wd[d] = 0; m_ill[d] = 0; m_ovf[d] = 0; m_we[d] = 0;
    end else begin
      m_we[d] = 0;
      if (start) begin
        m_phase[d] = 1; m_ptr[d] = 0; m_cnt[d] = 0; m_ill[d] = 0; m_ovf[d] = 0;
      end else if (m_phase[d] == 1 && valid) begin
        if (int'(op) > 22) begin
          m_ill[d] = 1;
        end else begin
          m_we[d]   = 1;
          m_addr[d] = m_ptr[d];
          m_wd[d]   = encode(int'(op), int'(rd), int'(rm), int'(rn), int'(imm));
          m_cnt[d]++;
          if (op == 5'd22) m_phase[d] = 2;
          else if (m_ptr[d] == depth(d) - 1) begin
            m_ovf[d]   = 1;
            m_phase[d] = 2;
          end
          if (m_ptr[d] < depth(d) - 1) m_ptr[d]++;
        end
      end
    end
  endtask

  // One clock: check the combinational ready, advance the model, then check registered outputs.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d_in_ready", d), 32'(o_rdy[d]), 32'(m_phase[d] == 1 && !start));
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_mem_we", d), 32'(o_we[d]), 32'(m_we[d]));
      check($sformatf("d%0d_busy", d), 32'(o_busy[d]), 32'(m_phase[d] == 1));
      check($sformatf("d%0d_done", d), 32'(o_done[d]), 32'(m_phase[d] == 2));
      check($sformatf("d%0d_err_illegal", d), 32'(o_ill[d]), 32'(m_ill[d]));
      check($sformatf("d%0d_err_overflow", d), 32'(o_ovf[d]), 32'(m_ovf[d]));
      check($sformatf("d%0d_word_count", d), 32'(o_cnt[d]), 32'(m_cnt[d]));
      if (m_we[d] || rst) begin
        check($sformatf("d%0d_mem_addr", d), 32'(o_addr[d]), 32'(m_addr[d]));
        check($sformatf("d%0d_mem_wdata", d), 32'(o_wd[d]), 32'(m_wd[d]));
      end
    end
  endtask

  task automatic drive(input bit v, input int o, input int a, input int b, input int c, input int i);
    valid = v;
    op    = 5'(o);
    rd    = 3'(a);
    rm    = 3'(b);
    rn    = 3'(c);
    imm   = 11'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_in_ready", 32'(if8.in_ready), 32'd0);
    rst = 1'b0;

    // Idle ignores traffic.
    drive(1, 7, 1, 2, 3, 0);
    step();
    check("idle_no_write", 32'(we8), 32'd0);

    pulse_start();
    drive(1, 7, 1, 2, 3, 0);
    step();
    check("tp_add_we", 32'(we8), 32'd1);
    check("tp_add_addr", 32'(addr8), 32'h00);
    check("tp_add_wdata", 32'(wd8), 32'h014C);
    check("tp_add_count", 32'(cnt8), 32'd1);

    // Back-to-back burst ending in HLT.
    pulse_start();
    drive(1, 3, 2, 0, 0, 'hAB); step(); check("tp_lhi", 32'(wd8), 32'h0AAB);
    drive(1, 14, 0, 0, 0, 'h10); step(); check("tp_bne", 32'(wd8), 32'hC110);
    drive(1, 17, 0, 0, 0, 'h7FF); step(); check("tp_jmp", 32'(wd8), 32'h87FF);
    drive(1, 16, 0, 0, 0, 'hFE); step(); check("tp_bal", 32'(wd8), 32'hCEFE);
    drive(1, 22, 0, 0, 0, 0); step();
    check("tp_hlt", 32'(wd8), 32'hE001);
    check("tp_hlt_addr", 32'(addr8), 32'd4);
    check("tp_hlt_done", 32'(done8), 32'd1);
    drive(1, 7, 1, 1, 1, 0); step();

    // Illegal code, then CMP at the unchanged address.
    pulse_start();
    drive(1, 25, 1, 2, 3, 5); step();
    check("tp_ill_flag", 32'(ill8), 32'd1);
    check("tp_ill_busy", 32'(busy8), 32'd1);
    check("tp_ill_nowe", 32'(we8), 32'd0);
    drive(1, 11, 0, 4, 5, 0); step();
    check("tp_cmp", 32'(wd8), 32'h3095);
    check("tp_cmp_addr", 32'(addr8), 32'd0);

    // Fill the small memory without HLT.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, k, 7 - k, 0, 0);
      step();
    end
    check("tp_ovf_flag", 32'(ovf2), 32'd1);
    check("tp_ovf_done", 32'(done2), 32'd1);
    check("tp_ovf_count", 32'(cnt2), 32'd4);
    check("tp_ovf_ready", 32'(if2.in_ready), 32'd0);
    drive(1, 0, 1, 1, 0, 0); step();

    // Restart mid-load with valid held.
    pulse_start();
    drive(1, 25, 0, 0, 0, 0); step();
    drive(1, 5, 1, 2, 3, 0); step();
    start = 1'b1;
    drive(1, 6, 4, 5, 6, 0); step();
    start = 1'b0;
    check("tp_restart_count", 32'(cnt8), 32'd0);
    check("tp_restart_ill", 32'(ill8), 32'd0);
    step();
    check("tp_restart_addr", 32'(addr8), 32'd0);

    // Reset while a write is already registered.
    drive(1, 8, 1, 2, 3, 0); step();
    rst = 1'b1;
    step();
    check("tp_rst_we", 32'(we8), 32'd0);
    check("tp_rst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;

    // Gaps between accepts.
    pulse_start();
    drive(1, 20, 0, 7, 0, 0); step(); check("tp_jr", 32'(wd8), 32'h98E0);
    drive(0, 21, 0, 3, 0, 0); step(); step();
    check("tp_gap_nowe", 32'(we8), 32'd0);
    drive(1, 21, 0, 3, 0, 0); step();
    check("tp_outr", 32'(wd8), 32'hE060);
    check("tp_outr_addr", 32'(addr8), 32'd1);
    drive(0, 0, 0, 0, 0, 0); step();

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 9) < 7,
            ($urandom_range(0, 9) == 0) ? $urandom_range(23, 31) : $urandom_range(0, 22),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 2047));
      step();
    end
    rst = 1'b0;
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts one mnemonic plus operand fields per handshake.
- Encodes each one into the team's 16-bit instruction word.
- Writes the words sequentially into instruction memory, starting at BASE_ADDR.
- Used by the bring-up loader and by benches to build programs without hand-coding hex. Load ends on HLT or when memory is full.

Parameters:
- ADDR_W, 8, instruction memory address width. Memory depth is 2^ADDR_W words.
- BASE_ADDR, 0, first address written after start.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins or restarts a load.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block accepts this cycle.
- op_sel  input  5  mnemonic code: 0 MOV, 1 ADDI, 2 SUBI, 3 LHI, 4 LLI, 5 LDR, 6 STR, 7 ADD, 8 ADC, 9 SUB, 10 SBB, 11 CMP, 12 BCC, 13 BCS, 14 BNE, 15 BEQ, 16 BAL, 17 JMP, 18 JAL_Label, 19 JAL_Rm, 20 JR, 21 OutR, 22 HLT. Codes 23-31 are illegal.
- rd, rm, rn  input  3 each  register fields.
- imm  input  11  immediate or displacement, right-aligned.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  encoded instruction word.
- busy  output  1  state is LOAD.
- done  output  1  load finished.
- err_illegal  output  1  sticky; an illegal op_sel was accepted.
- err_overflow  output  1  sticky; memory filled without HLT.
- word_count  output  ADDR_W+1  number of words written since start.

Behaviour:
- Reset (rst=1): state IDLE.
  - Cleared to 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, both error flags, word_count.
  - Reset takes priority over start and in_valid.
  - Reset mid-load abandons the load; a write already registered does not occur.
- States: IDLE, LOAD, DONE.
  - start in any state: go to LOAD; write pointer = BASE_ADDR; word_count, done and both error flags cleared.
- in_ready = (state==LOAD) && !start.
  - Accept = in_valid && in_ready.
  - start on the same cycle as in_valid: start wins; the instruction is not accepted.
- Latency: on the accept edge the word is encoded and registered. mem_we=1 with mem_addr/mem_wdata for exactly the next cycle.
  - On that accept edge the pointer increments and word_count increments.
  - Back-to-back accepts give one write per cycle.
- Encoding (bit ranges; unlisted bits are 0):
  - MOV: [15:11]=01011, [10:8]=rd, [7:5]=rm.
  - ADDI: [15:11]=00111. SUBI: [15:11]=01000. Both: [10:8]=rd, [7:5]=rm, [4:0]=imm[4:0].
  - LHI: [15:11]=00001. LLI: [15:11]=00010. JAL_Label: [15:11]=10001. All three: [10:8]=rd, [7:0]=imm[7:0].
  - LDR: [15:11]=00011. STR: [15:11]=00101. Both: [10:8]=rd, [7:5]=rm, [4:2]=rn.
  - ADD/ADC/SUB/SBB: [15:11]=00000, [10:8]=rd, [7:5]=rm, [4:2]=rn, [1:0]=00/01/10/11.
  - CMP: [15:11]=00110, [7:5]=rm, [4:2]=rn, [1:0]=01.
  - Branches: [15:8] = BCC 0xC3, BCS 0xC2, BNE 0xC1, BEQ 0xC0, BAL 0xCE; [7:0]=imm[7:0].
  - JMP: [15:11]=10000, [10:0]=imm[10:0].
  - JAL_Rm: [15:11]=10010, [10:8]=rd, [7:5]=rm.
  - JR: [15:11]=10011, [7:5]=rm.
  - OutR: [15:11]=11100, [7:5]=rm, [1:0]=00.
  - HLT: 0xE001.
  - Immediates wider than their field are silently truncated to the low bits.
- Illegal op_sel: the handshake completes, but no write, no pointer or count change. err_illegal is set; state stays LOAD.
- HLT accepted: the HLT word is written. The state moves to DONE on the accept edge, so done=1 from the cycle of the HLT write.
- Full: accepting a non-HLT word at address 2^ADDR_W-1 writes it, sets err_overflow, and moves to DONE. The pointer never wraps.
- DONE: in_ready=0, done=1, and the flags hold until start or rst.
- IDLE: in_ready=0, no writes.

Test Plan:
- Reset, then start, then ADD rd=1 rm=2 rn=3 -> next cycle mem_we=1, mem_addr=0x00, mem_wdata=0x014C; word_count=1.
- Back-to-back, in_valid held: LHI rd=2 imm=0xAB, BNE imm=0x10, JMP imm=0x7FF, BAL imm=0xFE, HLT.
  - Writes at 0..4 on consecutive cycles: 0x0AAB, 0xC110, 0x87FF, 0xCEFE, 0xE001.
  - done=1 from the HLT write cycle; in_ready=0 afterwards.
- op_sel=25 accepted -> no mem_we, err_illegal=1, busy stays 1. A following CMP rm=4 rn=5 writes 0x3095 at the unchanged address.
- ADDR_W=2, BASE_ADDR=0, four MOVs, no HLT -> writes at 0..3; after the fourth, err_overflow=1, done=1, in_ready=0; word_count=4.
- Mid-load checks:
  - start pulsed with in_valid=1 -> no accept that cycle; pointer back to BASE_ADDR; flags cleared.
  - rst during LOAD -> all outputs 0 on the next cycle, state IDLE.
- in_valid=0 gaps between JR rm=7 (0x98E0) and OutR rm=3 (0xE060) -> exactly one write per accept, consecutive addresses, no write during gaps.
